// File: rtl/nibble_compare_seq.sv
// Multi-cycle unsigned magnitude comparator: one 4-bit cascade step per clock, MSB nibble first.
// Optional early exit on first differing nibble: define NIBBLE_COMPARE_EARLY_EXIT_EN.
module nibble_compare_seq #(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / 4,
  localparam int SW      = $clog2(NIBBLES + 1)
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  output logic             oValid,
  input  logic             iReady,
  output logic [2:0]       oData,
  output logic [SW-1:0]    oSteps,
  output logic             oBusy
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_LT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opA_q, opA_d;
  logic [WIDTH-1:0]  opB_q, opB_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [2:0]        cascade_q, cascade_d;
  logic [2:0]        data_q, data_d;
  logic [SW-1:0]     steps_q, steps_d;

  logic [WIDTH-1:0]  aShift, bShift;
  logic [3:0]        aNib, bNib;
  logic [2:0]        stepRes;
  logic              bitFound;
  logic              lastStep;
  logic              decided;
  logic              finish;

  // State register and datapath registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      idx_q     <= IW'(NIBBLES - 1);
      cascade_q <= RES_EQ;
      data_q    <= 3'b000;
      steps_q   <= '0;
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      idx_q     <= idx_d;
      cascade_q <= cascade_d;
      data_q    <= data_d;
      steps_q   <= steps_d;
    end
  end

  // One cascade step: an already-decided cascade passes through untouched
  always_comb begin
    aShift   = opA_q >> (4 * int'(idx_q));
    bShift   = opB_q >> (4 * int'(idx_q));
    aNib     = aShift[3:0];
    bNib     = bShift[3:0];
    stepRes  = RES_EQ;
    bitFound = 1'b0;
    if (cascade_q == RES_GT || cascade_q == RES_LT) begin
      stepRes = cascade_q;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (!bitFound && (aNib[i] != bNib[i])) begin
          bitFound = 1'b1;
          stepRes  = aNib[i] ? RES_GT : RES_LT;
        end
      end
    end
  end

  always_comb begin
    lastStep = (idx_q == '0);
    decided  = (stepRes == RES_GT) || (stepRes == RES_LT);
`ifdef NIBBLE_COMPARE_EARLY_EXIT_EN
    finish   = lastStep || decided;
`else
    finish   = lastStep;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iValid) state_d = RUN;
      RUN:     if (finish) state_d = DONE;
      DONE:    if (iReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; operands are only captured on the accept edge
  always_comb begin
    opA_d     = opA_q;
    opB_d     = opB_q;
    idx_d     = idx_q;
    cascade_d = cascade_q;
    data_d    = data_q;
    steps_d   = steps_q;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          opA_d     = iData_a;
          opB_d     = iData_b;
          idx_d     = IW'(NIBBLES - 1);
          cascade_d = RES_EQ;
          steps_d   = '0;
        end
      end
      RUN: begin
        cascade_d = stepRes;
        steps_d   = steps_q + SW'(1);
        if (!lastStep) idx_d = idx_q - IW'(1);
        if (finish)    data_d = stepRes;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    oReady = (state_q == IDLE);
    oBusy  = (state_q == RUN);
    oValid = (state_q == DONE);
    oData  = data_q;
    oSteps = steps_q;
  end

endmodule
